// File: rtl/jtframe_board_ctrl.sv
// rtl/jtframe_board_ctrl.sv - PLL watchdog, reset sequencing and DB15 user-port joystick reader
module jtframe_board_ctrl #(
  parameter int PLL_RST_LEN    = 255,
  parameter int RST_HOLD       = 16,
  parameter int GAME_RST_EXTRA = 8,
  parameter int DIV            = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        pll_rst,
  input  logic        rst_req,
  input  logic        downloading,
  output logic        rst,
  output logic        game_rst,
  input  logic [1:0]  db15_mode,
  input  logic        joy_data,
  output logic        user_mode,
  output logic [6:0]  user_out,
  output logic [11:0] db15_joy1,
  output logic [11:0] db15_joy2
);

  localparam int PW = ($clog2(PLL_RST_LEN + 1) > 8) ? $clog2(PLL_RST_LEN + 1) : 8;
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int GW = $clog2(GAME_RST_EXTRA + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_UPDATE
  } state_t;

  logic [PW-1:0] pll_cnt;
  logic          last_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst     <= 1'b0;
      pll_cnt     <= PW'(8'hD0);
      last_locked <= 1'b0;
    end else begin
      last_locked <= pll_locked;
      if (last_locked && !pll_locked) begin
        pll_rst <= 1'b1;
        pll_cnt <= PW'(PLL_RST_LEN);
      end else if (pll_cnt != '0) begin
        pll_cnt <= pll_cnt - 1'b1;
      end else begin
        pll_rst <= 1'b0;
      end
    end
  end

  logic          cause, rst_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [GW-1:0] game_cnt;

  // rst_nxt is used so game_rst rises on the very same edge as rst
  always_comb begin
    cause    = rst_req | downloading | ~pll_locked | pll_rst;
    rst_nxt  = rst;
    hold_nxt = hold_cnt;
    if (cause) begin
      rst_nxt  = 1'b1;
      hold_nxt = HW'(RST_HOLD);
    end else if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - 1'b1;
      rst_nxt  = (hold_cnt != HW'(1));
    end else begin
      rst_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst      <= 1'b1;
      game_rst <= 1'b1;
      hold_cnt <= HW'(RST_HOLD);
      game_cnt <= GW'(GAME_RST_EXTRA);
    end else begin
      rst      <= rst_nxt;
      hold_cnt <= hold_nxt;
      if (rst_nxt) begin
        game_rst <= 1'b1;
        game_cnt <= GW'(GAME_RST_EXTRA);
      end else if (game_cnt != '0) begin
        game_cnt <= game_cnt - 1'b1;
      end else begin
        game_rst <= 1'b0;
      end
    end
  end

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic          tick, load_half;
  logic [4:0]    bit_idx;
  logic [23:0]   shift;
  logic          joy_clk, joy_load;

  assign tick      = (div == DW'(DIV - 1));
  assign joy_clk   = (state != ST_SHIFT_LO);
  assign joy_load  = (state != ST_LOAD);
  assign user_mode = |db15_mode;
  assign user_out  = user_mode ? {5'b11111, joy_clk, joy_load} : 7'h7F;

  always_comb begin
    state_nxt = state;
    if (db15_mode == 2'd0) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_LOAD;
        ST_LOAD:     if (tick && load_half) state_nxt = ST_SHIFT_LO;
        ST_SHIFT_LO: if (tick) state_nxt = ST_SHIFT_HI;
        ST_SHIFT_HI: if (tick) state_nxt = (bit_idx < 5'd24) ? ST_SHIFT_LO : ST_UPDATE;
        ST_UPDATE:   state_nxt = ST_LOAD;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Divider restarts after UPDATE so every LOAD pulse spans exactly two ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div       <= '0;
      load_half <= 1'b0;
      bit_idx   <= '0;
      shift     <= '0;
      db15_joy1 <= '0;
      db15_joy2 <= '0;
    end else begin
      state <= state_nxt;
      div   <= (state == ST_IDLE || state == ST_UPDATE || tick) ? '0 : div + 1'b1;
      if (state == ST_LOAD) begin
        bit_idx <= '0;
        if (tick) load_half <= ~load_half;
      end else begin
        load_half <= 1'b0;
      end
      if (state == ST_SHIFT_LO && state_nxt == ST_SHIFT_HI) begin
        shift[bit_idx] <= ~joy_data;
        bit_idx        <= bit_idx + 1'b1;
      end
      if (state_nxt == ST_IDLE) begin
        db15_joy1 <= '0;
        db15_joy2 <= '0;
      end else if (state == ST_UPDATE) begin
        db15_joy1 <= shift[11:0];
        db15_joy2 <= (db15_mode == 2'd1) ? 12'h000 : shift[23:12];
      end
    end
  end

endmodule

// File: tb/tb_jtframe_board_ctrl.sv
// tb/tb_jtframe_board_ctrl.sv - self-checking bench for jtframe_board_ctrl
module tb_jtframe_board_ctrl;

  localparam int DIV = 4;

  logic        clk, rst_n, pll_locked, pll_rst, rst_req, downloading, rst, game_rst;
  logic [1:0]  db15_mode;
  logic        joy_data, user_mode;
  logic [6:0]  user_out;
  logic [11:0] db15_joy1, db15_joy2;

  jtframe_board_ctrl #(.PLL_RST_LEN(255), .RST_HOLD(16), .GAME_RST_EXTRA(8), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_req(rst_req), .downloading(downloading), .rst(rst), .game_rst(game_rst),
    .db15_mode(db15_mode), .joy_data(joy_data), .user_mode(user_mode),
    .user_out(user_out), .db15_joy1(db15_joy1), .db15_joy2(db15_joy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int seq; int cyc; logic pll_rst; logic rst; logic game_rst;} rvec_t;
  typedef struct {logic [1:0] mode; logic [23:0] pat;} jvec_t;
  typedef struct {logic [11:0] j1; logic [11:0] j2;} exp_t;

  rvec_t rtbl[$];
  jvec_t jtbl[$];
  exp_t  sb[$];

  int compared = 0;
  int mismatched = 0;
  int ptr = 0;
  int ld_len = 0;
  int jidx = 0;
  int frames_done = 0;
  bit jactive = 1'b0;
  logic [23:0] pat = 24'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_at(input int seq, input int cyc);
    foreach (rtbl[i]) begin
      if (rtbl[i].seq == seq && rtbl[i].cyc == cyc) begin
        check($sformatf("seq%0d_cyc%0d_pll_rst", seq, cyc), pll_rst, rtbl[i].pll_rst);
        check($sformatf("seq%0d_cyc%0d_rst", seq, cyc), rst, rtbl[i].rst);
        check($sformatf("seq%0d_cyc%0d_game_rst", seq, cyc), game_rst, rtbl[i].game_rst);
      end
    end
  endtask

  // which: 0 = drop pll_locked, 1 = downloading, 2 = rst_req, 3 = nothing
  task automatic run_seq(input int seq, input int ncyc, input int which,
                         input int a0, input int a1, input int b0, input int b1);
    for (int k = 1; k <= ncyc; k++) begin
      bit on;
      on = (k >= a0 && k <= a1) || (k >= b0 && k <= b1);
      case (which)
        0: pll_locked = ~on;
        1: downloading = on;
        2: rst_req = on;
        default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
      check_at(seq, k);
    end
    pll_locked = 1'b1;
    downloading = 1'b0;
    rst_req = 1'b0;
  endtask

  // DB15 adapter model plus frame scoreboard
  initial begin
    bit prev_load, prev_clk, ld, ck;
    exp_t e;
    prev_load = 1'b1;
    prev_clk = 1'b1;
    joy_data = 1'b1;
    forever begin
      @(negedge clk);
      ld = user_out[0];
      ck = user_out[1];
      if (prev_load && !ld) begin
        check("frame_user_out_hi", user_out[6:2], 5'b11111);
        check("frame_user_mode", user_mode, 1'b1);
        if (ptr == 24 && sb.size() > 0) begin
          e = sb.pop_front();
          check($sformatf("frame%0d_joy1", frames_done), db15_joy1, e.j1);
          check($sformatf("frame%0d_joy2", frames_done), db15_joy2, e.j2);
          frames_done++;
        end
        if (jactive && jidx < jtbl.size()) begin
          db15_mode = jtbl[jidx].mode;
          pat = jtbl[jidx].pat;
          e.j1 = jtbl[jidx].pat[11:0];
          e.j2 = (jtbl[jidx].mode == 2'd1) ? 12'h000 : jtbl[jidx].pat[23:12];
          sb.push_back(e);
          jidx++;
        end
      end
      if (!prev_load && ld && user_mode) check("load_low_len", ld_len, 2 * DIV);
      if (!ld) begin
        ld_len = prev_load ? 1 : ld_len + 1;
        ptr = 0;
      end else if (!prev_clk && ck) begin
        ptr++;
      end
      prev_load = ld;
      prev_clk = ck;
      joy_data = (ptr < 24) ? ~pat[ptr] : 1'b1;
    end
  end

  initial begin
    bit ok;
    int f0;
    rtbl.push_back('{1, 1, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{1, 15, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{1, 16, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{1, 23, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{1, 24, 1'b0, 1'b0, 1'b0});
    rtbl.push_back('{2, 1, 1'b1, 1'b1, 1'b1});
    rtbl.push_back('{2, 256, 1'b1, 1'b1, 1'b1});
    rtbl.push_back('{2, 257, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{2, 272, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{2, 273, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{2, 280, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{2, 281, 1'b0, 1'b0, 1'b0});
    rtbl.push_back('{3, 1, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{3, 100, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{3, 115, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{3, 116, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{3, 123, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{3, 124, 1'b0, 1'b0, 1'b0});
    rtbl.push_back('{4, 1, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{4, 16, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{4, 17, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{4, 24, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{4, 25, 1'b0, 1'b0, 1'b0});
    rtbl.push_back('{5, 10, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{5, 12, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{5, 26, 1'b0, 1'b1, 1'b1});
    rtbl.push_back('{5, 27, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{5, 34, 1'b0, 1'b0, 1'b1});
    rtbl.push_back('{5, 35, 1'b0, 1'b0, 1'b0});
    jtbl.push_back('{2'd2, 24'h800001});
    jtbl.push_back('{2'd1, 24'h800001});
    jtbl.push_back('{2'd3, 24'hA5C3F0});
    jtbl.push_back('{2'd2, 24'h123456});
    jtbl.push_back('{2'd1, 24'hFFFFFF});
    jtbl.push_back('{2'd2, 24'h000000});
    jtbl.push_back('{2'd2, 24'h800001});

    rst_n = 1'b0;
    pll_locked = 1'b1;
    rst_req = 1'b0;
    downloading = 1'b0;
    db15_mode = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_rst", rst, 1'b1);
    check("reset_game_rst", game_rst, 1'b1);
    check("reset_pll_rst", pll_rst, 1'b0);
    check("reset_user_out", user_out, 7'h7F);
    check("reset_user_mode", user_mode, 1'b0);
    check("reset_joy1", db15_joy1, 12'h000);
    check("reset_joy2", db15_joy2, 12'h000);
    rst_n = 1'b1;

    run_seq(1, 26, 3, 0, -1, 0, -1);
    run_seq(2, 283, 0, 1, 1, 0, -1);
    run_seq(3, 126, 1, 1, 100, 0, -1);
    run_seq(4, 27, 2, 1, 1, 0, -1);
    run_seq(5, 37, 2, 1, 1, 11, 11);

    db15_mode = jtbl[0].mode;
    jactive = 1'b1;
    for (int i = 0; i < 4000 && frames_done < jtbl.size(); i++) @(negedge clk);
    check("frames_done", frames_done, jtbl.size());
    jactive = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ptr >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_reach_mid_shift", ok, 1'b1);
    check("held_joy1", db15_joy1, 12'h001);
    check("held_joy2", db15_joy2, 12'h800);
    db15_mode = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check("abort_user_out", user_out, 7'h7F);
    check("abort_user_mode", user_mode, 1'b0);
    check("abort_joy1", db15_joy1, 12'h000);
    check("abort_joy2", db15_joy2, 12'h000);
    repeat (5) @(negedge clk);

    pat = 24'h5A3C96;
    sb.push_back('{12'hC96, 12'h000});
    f0 = frames_done;
    db15_mode = 2'd1;
    @(posedge clk);
    @(negedge clk);
    check("restart_load_low", user_out[0], 1'b0);
    check("restart_clk_high", user_out[1], 1'b1);
    for (int i = 0; i < 600 && frames_done == f0; i++) @(negedge clk);
    check("restart_frame_done", frames_done, f0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
